// File: rtl/cordic_vec_byte_sequencer.sv
// rtl/cordic_vec_byte_sequencer.sv - byte-wide operand loader and result streamer for the CORDIC vectoring pipeline
// One operation in flight: LOAD 2*NB bytes, wait out the pipeline latency, stream NB+4 result bytes.
module cordic_vec_byte_sequencer #(
   parameter int WIDTH = 16,
   parameter int LAT   = 17
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [WIDTH-1:0] x_start,
   output logic signed [WIDTH-1:0] y_start,
   input  logic signed [WIDTH-1:0] magnitude,
   input  logic [31:0]             phase,
   output logic [7:0]              out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy
);

   localparam int NB  = WIDTH / 8;
   localparam int NIN = 2 * NB;
   localparam int NO  = NB + 4;
   localparam int CW  = $clog2(((NO > NIN) ? NO : NIN) + 1);
   localparam int WW  = $clog2(LAT + 1);

   typedef enum logic [1:0] {S_LOAD, S_WAIT, S_SEND} state_t;

   state_t            state;
   logic [CW-1:0]     byte_cnt;
   logic [WW-1:0]     wait_cnt;
   logic [WIDTH-1:0]  x_sh, y_sh, x_next, y_next;
   logic [WIDTH-1:0]  mag_q;
   logic [31:0]       ph_q;
   logic [WIDTH+31:0] res;
   logic [7:0]        out_next;

   assign res = {ph_q, mag_q};

   // Shadow images with the incoming byte merged in, and the next result byte to present
   always_comb begin
      x_next   = x_sh;
      y_next   = y_sh;
      out_next = '0;
      for (int i = 0; i < NB; i++) begin
         if (byte_cnt == CW'(i))      x_next[8*i +: 8] = in_data;
         if (byte_cnt == CW'(NB + i)) y_next[8*i +: 8] = in_data;
      end
      for (int i = 0; i < NO; i++) begin
         if (byte_cnt + CW'(1) == CW'(i)) out_next = res[8*i +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_LOAD;
         byte_cnt  <= '0;
         wait_cnt  <= '0;
         x_sh      <= '0;
         y_sh      <= '0;
         x_start   <= '0;
         y_start   <= '0;
         mag_q     <= '0;
         ph_q      <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (in_valid && in_ready) begin
                  x_sh <= x_next;
                  y_sh <= y_next;
                  if (byte_cnt == CW'(NIN - 1)) begin
                     x_start  <= x_next;
                     y_start  <= y_next;
                     byte_cnt <= '0;
                     wait_cnt <= '0;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                     state    <= S_WAIT;
                  end else begin
                     byte_cnt <= byte_cnt + CW'(1);
                  end
               end
            end
            S_WAIT: begin
               if (wait_cnt == WW'(LAT)) begin
                  mag_q     <= magnitude;
                  ph_q      <= phase;
                  out_data  <= magnitude[7:0];
                  out_valid <= 1'b1;
                  byte_cnt  <= '0;
                  state     <= S_SEND;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            S_SEND: begin
               if (out_ready) begin
                  if (byte_cnt == CW'(NO - 1)) begin
                     byte_cnt  <= '0;
                     out_data  <= '0;
                     out_valid <= 1'b0;
                     in_ready  <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_LOAD;
                  end else begin
                     byte_cnt <= byte_cnt + CW'(1);
                     out_data <= out_next;
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vec_byte_sequencer.sv
// tb/tb_cordic_vec_byte_sequencer.sv - self-checking bench with an ideal real-arithmetic CORDIC pipeline model
module tb_cordic_vec_byte_sequencer;

   localparam int WIDTH = 16;
   localparam int LAT   = 17;

   logic               clock, reset;
   logic [7:0]         in_data;
   logic               in_valid, in_ready;
   logic [WIDTH-1:0]   x_start, y_start, magnitude;
   logic [31:0]        phase;
   logic [7:0]         out_data;
   logic               out_valid, out_ready, busy;

   int n_chk  = 0;
   int n_fail = 0;

   cordic_vec_byte_sequencer #(.WIDTH(WIDTH), .LAT(LAT)) dut (
      .clock(clock), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .x_start(x_start), .y_start(y_start),
      .magnitude(magnitude), .phase(phase),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Ideal vectoring result {phase, magnitude}: sqrt(x^2+y^2) and atan2(y,x)/pi in Q1.31
   function automatic logic [47:0] cordic_ref(input logic signed [15:0] x, input logic signed [15:0] y);
      real    m, p;
      longint mi, pi_l;
      m    = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      p    = $atan2(real'(y), real'(x)) / 3.14159265358979323846 * 2147483648.0;
      mi   = longint'(m);
      pi_l = longint'(p);
      return {pi_l[31:0], mi[15:0]};
   endfunction

   // Fixed-latency pipeline: input register plus WIDTH stages
   logic [47:0] pipe [LAT];
   always @(posedge clock) begin
      pipe[0] <= cordic_ref(x_start, y_start);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign magnitude = pipe[LAT-1][15:0];
   assign phase     = pipe[LAT-1][47:16];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [15:0] x, input logic [15:0] y, input bit bp, input int gap);
      logic [47:0] exp, t;
      logic [31:0] ops;
      int edges;
      exp = cordic_ref(x, y);
      ops = {y, x};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (gap > 0 && i == 2) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clock);
            check("partial_in_ready", in_ready, 1);
            check("partial_busy", busy, 0);
         end
         in_data  = ops[8*i +: 8];
         in_valid = 1'b1;
         check("load_in_ready", in_ready, 1);
         @(posedge clock);
      end
      @(negedge clock);
      in_valid = bp;
      in_data  = 8'hA5;
      check("wait_in_ready", in_ready, 0);
      check("wait_busy", busy, 1);
      check("x_start", x_start, x);
      check("y_start", y_start, y);
      edges = 0;
      while (!out_valid && edges < 60) begin
         @(posedge clock);
         edges++;
         @(negedge clock);
      end
      check("latency_edges", edges, LAT + 1);
      for (int i = 0; i < 6; i++) begin
         t = exp >> (8 * i);
         if (bp && i == 2) begin
            out_ready = 1'b0;
            repeat (5) begin
               in_data = 8'($urandom);
               check("bp_out_valid", out_valid, 1);
               check("bp_out_data", out_data, t[7:0]);
               check("bp_in_ready", in_ready, 0);
               @(posedge clock);
               @(negedge clock);
            end
            out_ready = 1'b1;
         end
         if (i == 5) in_valid = 1'b0;
         check("send_out_valid", out_valid, 1);
         check("send_out_data", out_data, t[7:0]);
         @(posedge clock);
         @(negedge clock);
      end
      check("done_out_valid", out_valid, 0);
      check("done_in_ready", in_ready, 1);
      check("done_busy", busy, 0);
   endtask

   initial begin
      int rx, ry, hits;
      logic [15:0] xr, yr;
      logic [31:0] ops;

      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_x_start", x_start, 0);
      check("rst_y_start", y_start, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      reset = 1'b0;

      do_op(16'h4000, 16'h0000, 1'b0, 0);
      do_op(16'h0000, 16'h4000, 1'b0, 0);
      do_op(16'hC000, 16'h0000, 1'b0, 0);
      do_op(16'h1234, 16'hE000, 1'b1, 0);
      do_op(16'hF123, 16'h2345, 1'b0, 30);

      // Reset while wait_cnt==8 must abort without any result bytes
      ops = {16'h3000, 16'h1000};
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         in_data = ops[8*i +: 8];
         in_valid = 1'b1;
         @(posedge clock);
      end
      @(negedge clock);
      in_valid = 1'b0;
      repeat (8) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_in_ready", in_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_x_start", x_start, 0);
      check("abort_y_start", y_start, 0);
      out_ready = 1'b1;
      hits = 0;
      repeat (30) begin
         @(negedge clock);
         if (out_valid) hits++;
      end
      check("abort_no_output", hits, 0);
      do_op(16'h2000, 16'hD000, 1'b0, 0);

      for (int n = 0; n < 6; n++) begin
         rx = int'($urandom_range(32000)) - 16000;
         ry = int'($urandom_range(32000)) - 16000;
         xr = rx[15:0];
         yr = ry[15:0];
         do_op(xr, yr, n[0], (n == 3) ? 7 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
